// File: rtl/regfile_pkg.sv
// Shared widths, types and select classification for the ALU register file.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_REGS   = 1 << DEF_ADDR_WIDTH;

    typedef logic [DEF_DATA_WIDTH-1:0] reg_word_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ONE,
        SEL_MULTI
    } sel_class_t;

endpackage

// File: rtl/regfile_bank_onehot_check.sv
// Classifies a normalised select vector as zero-, one- or multi-hot and encodes the hot index.
module onehot_check
    import regfile_pkg::*;
#(
    parameter int N     = DEF_NUM_REGS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_sel_n,
    output logic             o_is_zero,
    output logic             o_is_onehot,
    output logic             o_is_multi,
    output logic [IDX_W-1:0] o_index
);

    logic [N-1:0] w_sel_m1;

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign w_sel_m1    = i_sel_n - N'(1);
    assign o_is_zero   = (i_sel_n == '0);
    assign o_is_onehot = !o_is_zero && ((i_sel_n & w_sel_m1) == '0);
    assign o_is_multi  = !o_is_zero && !o_is_onehot;

    // OR-encoding is exact for one-hot input; callers ignore it otherwise.
    always_comb begin
        o_index = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel_n[i]) o_index = o_index | IDX_W'(i);
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// Register array fed by the one-hot write decoder, with two registered read ports and a sticky select-error flag.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit SEL_ACTIVE = 1'b1,
    parameter bit ZERO_REG   = 1'b1,
    localparam int NUM_REGS  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [NUM_REGS-1:0]   wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid,
    output logic                  sel_err,
    input  logic                  sel_err_clr
);

    logic [NUM_REGS-1:0]   w_sel_n;
    logic                  w_is_zero;
    logic                  w_is_onehot;
    logic                  w_is_multi;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    sel_class_t            w_sel_class;
    logic                  w_wr_hit;
    logic                  w_set_err;
    logic [DATA_WIDTH-1:0] w_rd_next_a;
    logic [DATA_WIDTH-1:0] w_rd_next_b;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_rd_data_a;
    logic [DATA_WIDTH-1:0] r_rd_data_b;
    logic                  r_rd_valid;
    logic                  r_sel_err;

    assign w_sel_n = SEL_ACTIVE ? wr_sel : ~wr_sel;

    onehot_check #(
        .N     (NUM_REGS),
        .IDX_W (ADDR_WIDTH)
    ) u_onehot_check (
        .i_sel_n     (w_sel_n),
        .o_is_zero   (w_is_zero),
        .o_is_onehot (w_is_onehot),
        .o_is_multi  (w_is_multi),
        .o_index     (w_wr_idx)
    );

    always_comb begin
        w_sel_class = SEL_NONE;
        case ({w_is_multi, w_is_onehot, w_is_zero})
            3'b001:  w_sel_class = SEL_NONE;
            3'b010:  w_sel_class = SEL_ONE;
            3'b100:  w_sel_class = SEL_MULTI;
            default: w_sel_class = SEL_NONE;
        endcase
    end

    // A write aimed at a hardwired-zero register is dropped without raising an error.
    assign w_wr_hit  = wr_en && (w_sel_class == SEL_ONE) && !(ZERO_REG && (w_wr_idx == '0));
    assign w_set_err = wr_en && (w_sel_class == SEL_MULTI);

    // Write-first bypass; the hardwired-zero register overrides everything.
    always_comb begin
        w_rd_next_a = r_regs[rd_addr_a];
        w_rd_next_b = r_regs[rd_addr_b];
        if (w_wr_hit && (rd_addr_a == w_wr_idx)) w_rd_next_a = wr_data;
        if (w_wr_hit && (rd_addr_b == w_wr_idx)) w_rd_next_b = wr_data;
        if (ZERO_REG && (rd_addr_a == '0)) w_rd_next_a = '0;
        if (ZERO_REG && (rd_addr_b == '0)) w_rd_next_b = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array is reset explicitly because the first read after reset must return 0.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_valid  <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_wr_hit) r_regs[w_wr_idx] <= wr_data;
            if (w_set_err)        r_sel_err <= 1'b1;
            else if (sel_err_clr) r_sel_err <= 1'b0;
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data_a <= w_rd_next_a;
                r_rd_data_b <= w_rd_next_b;
            end
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_valid  = r_rd_valid;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_regfile_bank.sv
// Scoreboard bench: drivers push expected read results, monitors pop them whenever rd_valid is seen.
module tb_regfile_bank;
    import regfile_pkg::*;

    typedef struct {
        int        id;
        reg_word_t a;
        reg_word_t b;
        logic      err;
    } exp_t;

    bit clk;
    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int id_main  = 0;
    int id_lo    = 0;
    exp_t q_main[$];
    exp_t q_lo[$];

    // Active-high select, register 0 hardwired to zero.
    logic        rst_n, wr_en, rd_en, sel_err_clr;
    logic [31:0] wr_sel, wr_data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid, sel_err;

    // Active-low select, register 0 writable.
    logic        lo_rst_n, lo_wr_en, lo_rd_en, lo_sel_err_clr;
    logic [31:0] lo_wr_sel, lo_wr_data;
    logic [4:0]  lo_rd_addr_a, lo_rd_addr_b;
    logic [31:0] lo_rd_data_a, lo_rd_data_b;
    logic        lo_rd_valid, lo_sel_err;

    regfile_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SEL_ACTIVE(1'b1), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
        .sel_err(sel_err), .sel_err_clr(sel_err_clr)
    );

    regfile_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SEL_ACTIVE(1'b0), .ZERO_REG(1'b0)) dut_lo (
        .clk(clk), .rst_n(lo_rst_n), .wr_en(lo_wr_en), .wr_sel(lo_wr_sel), .wr_data(lo_wr_data),
        .rd_en(lo_rd_en), .rd_addr_a(lo_rd_addr_a), .rd_addr_b(lo_rd_addr_b),
        .rd_data_a(lo_rd_data_a), .rd_data_b(lo_rd_data_b), .rd_valid(lo_rd_valid),
        .sel_err(lo_sel_err), .sel_err_clr(lo_sel_err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mexp(input reg_word_t a, input reg_word_t b, input logic err);
        q_main.push_back('{id_main, a, b, err});
        id_main++;
    endtask

    task automatic lexp(input reg_word_t a, input reg_word_t b, input logic err);
        q_lo.push_back('{id_lo, a, b, err});
        id_lo++;
    endtask

    task automatic mstep(input logic rst, input logic we, input logic [31:0] sel, input logic [31:0] data,
                         input logic re, input logic [4:0] a, input logic [4:0] b, input logic clr);
        rst_n = rst; wr_en = we; wr_sel = sel; wr_data = data;
        rd_en = re; rd_addr_a = a; rd_addr_b = b; sel_err_clr = clr;
        @(negedge clk);
    endtask

    task automatic lstep(input logic rst, input logic we, input logic [31:0] sel, input logic [31:0] data,
                         input logic re, input logic [4:0] a, input logic [4:0] b, input logic clr);
        lo_rst_n = rst; lo_wr_en = we; lo_wr_sel = sel; lo_wr_data = data;
        lo_rd_en = re; lo_rd_addr_a = a; lo_rd_addr_b = b; lo_sel_err_clr = clr;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_valid", 32'(rd_valid), 32'd0);
            end else begin
                exp_t e;
                e = q_main.pop_front();
                check($sformatf("main_rd_a[%0d]", e.id), rd_data_a, e.a);
                check($sformatf("main_rd_b[%0d]", e.id), rd_data_b, e.b);
                check($sformatf("main_sel_err[%0d]", e.id), 32'(sel_err), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (lo_rd_valid === 1'b1) begin
            if (q_lo.size() == 0) begin
                check("lo_unexpected_valid", 32'(lo_rd_valid), 32'd0);
            end else begin
                exp_t e;
                e = q_lo.pop_front();
                check($sformatf("lo_rd_a[%0d]", e.id), lo_rd_data_a, e.a);
                check($sformatf("lo_rd_b[%0d]", e.id), lo_rd_data_b, e.b);
                check($sformatf("lo_sel_err[%0d]", e.id), 32'(lo_sel_err), 32'(e.err));
            end
        end
    end

    task automatic main_seq();
        mstep(0, 1, 32'h0000_0020, 32'hFFFF_FFFF, 1, 5, 31, 0);
        mstep(0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        mexp(32'h0, 32'h0, 0);
        mstep(1, 0, 32'h0, 32'h0, 1, 5, 31, 0);
        mstep(1, 1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 0, 0, 0);
        mexp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        mstep(1, 0, 32'h0, 32'h0, 1, 3, 3, 0);
        mexp(32'h1234_5678, 32'h1234_5678, 0);
        mstep(1, 1, 32'h8000_0000, 32'h1234_5678, 1, 31, 31, 0);
        mexp(32'h0, 32'hDEAD_BEEF, 0);
        mstep(1, 1, 32'h0000_0001, 32'hFFFF_FFFF, 1, 0, 3, 0);
        mexp(32'h0, 32'h1234_5678, 0);
        mstep(1, 0, 32'h0, 32'h0, 1, 0, 31, 0);
        mstep(1, 1, 32'h0000_0002, 32'h0000_0011, 0, 0, 0, 0);
        mstep(1, 1, 32'h0000_0004, 32'h0000_0022, 0, 0, 0, 0);
        mexp(32'h11, 32'h22, 1);
        mstep(1, 1, 32'h0000_0006, 32'hA5A5_A5A5, 1, 1, 2, 0);
        mexp(32'h11, 32'h22, 1);
        mstep(1, 0, 32'h0000_0006, 32'hA5A5_A5A5, 1, 1, 2, 0);
        mexp(32'h0, 32'h0, 1);
        mstep(1, 1, 32'h0000_0030, 32'h5A5A_5A5A, 1, 4, 5, 1);
        mexp(32'h0, 32'h0, 0);
        mstep(1, 0, 32'h0, 32'h0, 1, 4, 5, 1);
        mexp(32'h11, 32'h22, 0);
        mstep(1, 0, 32'h0000_0006, 32'hFFFF_FFFF, 1, 1, 2, 0);
        mexp(32'h0, 32'h11, 0);
        mstep(1, 1, 32'h0, 32'hFFFF_FFFF, 1, 0, 1, 0);
        mstep(1, 1, 32'h0000_0002, 32'h0000_0099, 0, 7, 7, 0);
        check("main_hold_a", rd_data_a, 32'h0);
        check("main_hold_b", rd_data_b, 32'h11);
        check("main_idle_valid", 32'(rd_valid), 32'd0);
        mexp(32'h99, 32'h99, 0);
        mstep(1, 0, 32'h0, 32'h0, 1, 1, 1, 0);
        mstep(1, 1, 32'h0000_0003, 32'h0, 0, 0, 0, 0);
        check("main_err_before_reset", 32'(sel_err), 32'd1);
        mstep(0, 1, 32'h0000_0008, 32'h5555_5555, 1, 3, 1, 0);
        check("main_err_after_reset", 32'(sel_err), 32'd0);
        check("main_data_after_reset", rd_data_a, 32'h0);
        mexp(32'h0, 32'h0, 0);
        mstep(1, 0, 32'h0, 32'h0, 1, 3, 1, 0);
        mstep(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic lo_seq();
        lstep(0, 0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0);
        lstep(1, 1, ~32'h0000_0010, 32'h0000_00AA, 0, 0, 0, 0);
        lexp(32'hAA, 32'hAA, 0);
        lstep(1, 0, 32'hFFFF_FFFF, 32'h0, 1, 4, 4, 0);
        lexp(32'hAA, 32'h0, 0);
        lstep(1, 1, 32'hFFFF_FFFF, 32'h0000_0077, 1, 4, 0, 0);
        lexp(32'hC3, 32'hAA, 0);
        lstep(1, 1, ~32'h0000_0001, 32'h0000_00C3, 1, 0, 4, 0);
        lexp(32'h0, 32'h0, 1);
        lstep(1, 1, ~32'h0000_0006, 32'h0000_0001, 1, 1, 2, 0);
        lexp(32'hC3, 32'hAA, 1);
        lstep(1, 0, 32'hFFFF_FFFF, 32'h0, 1, 0, 4, 0);
        lstep(1, 0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

    initial begin
        rst_n = 0; wr_en = 0; wr_sel = '0; wr_data = '0;
        rd_en = 0; rd_addr_a = '0; rd_addr_b = '0; sel_err_clr = 0;
        lo_rst_n = 0; lo_wr_en = 0; lo_wr_sel = '1; lo_wr_data = '0;
        lo_rd_en = 0; lo_rd_addr_a = '0; lo_rd_addr_b = '0; lo_sel_err_clr = 0;
        @(negedge clk);
        fork
            main_seq();
            lo_seq();
        join
        repeat (2) @(negedge clk);
        check("main_queue_drained", 32'(q_main.size()), 32'd0);
        check("lo_queue_drained", 32'(q_lo.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
